// File: rtl/pulse_window_counter.sv
// pulse_window_counter: counts synch_in rising edges over a programmable gate window and hands each count downstream via valid/ready
module pulse_window_counter #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             synch_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    logic [1:0]       state;
    logic             prev;
    logic [CNT_W-1:0] acc;
    logic             ovf;
    logic [WIN_W-1:0] timer;
    logic [CNT_W-1:0] held_cnt;
    logic             held_ovf;
    logic             edge_hit;
    logic             out_free;
    logic [CNT_W-1:0] fin_cnt;
    logic             fin_ovf;
    logic [WIN_W-1:0] win_load;
    // edge detect, saturating next-count value, output-register availability and window reload value
    always_comb begin
        edge_hit = synch_in & ~prev;
        out_free = ~count_valid | count_ready;
        fin_cnt  = (edge_hit & !(&acc)) ? acc + 1'b1 : acc;
        fin_ovf  = ovf | (edge_hit & (&acc));
        win_load = (window_len == '0) ? '0 : window_len - 1'b1;
        busy     = state != IDLE;
    end
    // window FSM, accumulator and output register with valid/ready handoff
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            prev        <= 1'b0;
            acc         <= '0;
            ovf         <= 1'b0;
            timer       <= '0;
            held_cnt    <= '0;
            held_ovf    <= 1'b0;
            count_out   <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            prev <= synch_in;
            if (count_valid && count_ready) count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        timer <= win_load;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= IDLE;
                    end else if (timer == '0) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        if (out_free) begin
                            count_out   <= fin_cnt;
                            overflow    <= fin_ovf;
                            count_valid <= 1'b1;
                            timer       <= win_load;
                        end else begin
                            held_cnt <= fin_cnt;
                            held_ovf <= fin_ovf;
                            state    <= HOLD;
                        end
                    end else begin
                        acc   <= fin_cnt;
                        ovf   <= fin_ovf;
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_free) begin
                        count_out   <= held_cnt;
                        overflow    <= held_ovf;
                        count_valid <= 1'b1;
                        timer       <= win_load;
                        acc         <= '0;
                        ovf         <= 1'b0;
                        state       <= enable ? COUNT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_window_counter.sv
// tb_pulse_window_counter: table-driven windows plus hand sequences, results checked through a scoreboard queue
module tb_pulse_window_counter;
    localparam int CNT_W = 4;
    localparam int WIN_W = 24;
    logic             clock;
    logic             reset;
    logic             enable;
    logic             synch_in;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] count_out;
    logic             overflow;
    logic             count_valid;
    logic             count_ready;
    logic             busy;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int cnt;
        int ovf;
    } res_t;
    typedef struct {
        int len;
        int start;
        int n;
        int spacing;
        int width;
        int exp_cnt;
        int exp_ovf;
    } vec_t;
    res_t exp_q[$];
    vec_t vecs[7];

    pulse_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .synch_in(synch_in),
        .window_len(window_len),
        .count_out(count_out),
        .overflow(overflow),
        .count_valid(count_valid),
        .count_ready(count_ready),
        .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_res(input int cnt, input int ovf);
        res_t r;
        r.cnt = cnt;
        r.ovf = ovf;
        exp_q.push_back(r);
    endtask

    function automatic logic pulse_at(input vec_t v, input int j);
        if (j < v.start) return 1'b0;
        return ((j - v.start) % v.spacing < v.width) && ((j - v.start) / v.spacing < v.n);
    endfunction

    // scoreboard: every accepted result must match the oldest expectation
    always @(negedge clock) begin
        if (reset && count_valid && count_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got %0d expected none", count_out);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("result_cnt", int'(count_out), r.cnt);
                check("result_ovf", int'(overflow), r.ovf);
            end
        end
    end

    initial begin
        vecs[0] = '{len: 100, start: 5,  n: 7,  spacing: 10, width: 1, exp_cnt: 7,  exp_ovf: 0};
        vecs[1] = '{len: 50,  start: 2,  n: 3,  spacing: 10, width: 5, exp_cnt: 3,  exp_ovf: 0};
        vecs[2] = '{len: 200, start: 1,  n: 20, spacing: 10, width: 1, exp_cnt: 15, exp_ovf: 1};
        vecs[3] = '{len: 10,  start: 10, n: 1,  spacing: 1,  width: 1, exp_cnt: 1,  exp_ovf: 0};
        vecs[4] = '{len: 20,  start: 1,  n: 0,  spacing: 1,  width: 1, exp_cnt: 0,  exp_ovf: 0};
        vecs[5] = '{len: 40,  start: 1,  n: 15, spacing: 2,  width: 1, exp_cnt: 15, exp_ovf: 0};
        vecs[6] = '{len: 40,  start: 1,  n: 16, spacing: 2,  width: 1, exp_cnt: 15, exp_ovf: 1};
        reset = 1'b0;
        enable = 1'b1;
        synch_in = 1'b0;
        window_len = 24'd5;
        count_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            synch_in = ~synch_in;
            tick();
        end
        check("rst_count_out", int'(count_out), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_valid", int'(count_valid), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        enable = 1'b0;
        synch_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("idle_busy", int'(busy), 0);
        check("idle_valid", int'(count_valid), 0);

        for (int k = 0; k < 7; k++) begin
            window_len = WIN_W'(vecs[k].len);
            count_ready = 1'b1;
            synch_in = 1'b0;
            expect_res(vecs[k].exp_cnt, vecs[k].exp_ovf);
            enable = 1'b1;
            tick();
            for (int j = 1; j <= vecs[k].len; j++) begin
                synch_in = pulse_at(vecs[k], j);
                if (j == vecs[k].len) check("latency_pre", int'(count_valid), 0);
                tick();
            end
            check("latency_valid", int'(count_valid), 1);
            check("no_gap_busy", int'(busy), 1);
            synch_in = 1'b0;
            enable = 1'b0;
            tick();
            check("stop_busy", int'(busy), 0);
            tick();
        end

        window_len = 24'd20;
        count_ready = 1'b0;
        expect_res(2, 0);
        expect_res(4, 0);
        enable = 1'b1;
        tick();
        for (int j = 1; j <= 40; j++) begin
            synch_in = (j == 3 || j == 8 || j == 23 || j == 27 || j == 31 || j == 35);
            tick();
        end
        check("hold_valid", int'(count_valid), 1);
        check("hold_cnt", int'(count_out), 2);
        check("hold_busy", int'(busy), 1);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            synch_in = ~synch_in;
            tick();
        end
        synch_in = 1'b0;
        check("stall_cnt", int'(count_out), 2);
        check("stall_valid", int'(count_valid), 1);
        check("stall_busy", int'(busy), 1);
        count_ready = 1'b1;
        tick();
        check("hold_reload_valid", int'(count_valid), 1);
        check("hold_reload_cnt", int'(count_out), 4);
        tick();
        check("drain_valid", int'(count_valid), 0);
        check("drain_busy", int'(busy), 0);

        window_len = 24'd100;
        enable = 1'b1;
        tick();
        for (int j = 1; j <= 29; j++) begin
            synch_in = (j % 5 == 1);
            tick();
        end
        synch_in = 1'b0;
        enable = 1'b0;
        tick();
        check("abort_busy", int'(busy), 0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_no_result", int'(count_valid), 0);

        window_len = 24'd0;
        expect_res(1, 0);
        expect_res(0, 0);
        enable = 1'b1;
        tick();
        synch_in = 1'b1;
        tick();
        check("len0_valid", int'(count_valid), 1);
        synch_in = 1'b0;
        tick();
        check("len0_b2b_valid", int'(count_valid), 1);
        enable = 1'b0;
        tick();
        check("len0_done_valid", int'(count_valid), 0);
        tick();

        window_len = 24'd5;
        synch_in = 1'b1;
        tick();
        expect_res(0, 0);
        enable = 1'b1;
        tick();
        for (int j = 1; j <= 5; j++) tick();
        check("prehigh_valid", int'(count_valid), 1);
        enable = 1'b0;
        synch_in = 1'b0;
        tick();
        tick();

        window_len = 24'd10;
        count_ready = 1'b0;
        enable = 1'b1;
        for (int j = 0; j < 25; j++) tick();
        reset = 1'b0;
        tick();
        check("midhold_rst_valid", int'(count_valid), 0);
        check("midhold_rst_busy", int'(busy), 0);
        reset = 1'b1;
        enable = 1'b0;
        count_ready = 1'b1;
        tick();
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_window_counter.md
Name: pulse_window_counter

Overview:
- Downstream consumer of the asynchronous-input pulse synchroniser.
- Takes its clock-domain pulse output and counts rising edges over a programmable gate window.
- Hands each window's count to the next stage through a valid/ready handshake.
- Used for event-rate measurement of external asynchronous signals.

Parameters:
- CNT_W, 16, width of event count result.
- WIN_W, 24, width of window length input.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  run measurement windows while high.
- synch_in  input  1  synchronised pulse from upstream synchroniser; may stay high more than one cycle.
- window_len  input  WIN_W  gate length in clock cycles; sampled on window start; 0 treated as 1.
- count_out  output  CNT_W  event count of completed window.
- overflow  output  1  count_out saturated in this result.
- count_valid  output  1  count_out/overflow hold a result.
- count_ready  input  1  downstream accepts result when high with count_valid.
- busy  output  1  high in COUNT or HOLD.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; count_out=0, overflow=0, count_valid=0, busy=0; edge register, accumulator, timer and sticky overflow all cleared. Applies mid-window and mid-HOLD; any pending result is dropped.
- Edge detect: prev <= synch_in every cycle. event = synch_in & ~prev. A level held N cycles counts once. prev updates in all states, so a level already high on window start is not counted.
- IDLE:
  - busy=0.
  - If enable: load timer=max(window_len,1)-1, clear acc and sticky ovf, go COUNT.
- COUNT (busy=1):
  - Each cycle, if event: acc increments, saturating at 2^CNT_W-1. An increment attempted at max sets sticky ovf.
  - Timer decrements each cycle. Window = exactly max(window_len,1) COUNT cycles; an event on the last cycle is included.
  - enable low in any COUNT cycle: abort, discard acc, no result, go IDLE (takes precedence over window end).
  - Last cycle (timer==0), final value = acc+event (saturated):
    - If output register free (count_valid==0, or count_valid&count_ready this cycle): load count_out/overflow, count_valid=1 next cycle. Reload timer from current window_len, clear acc, stay COUNT. Back-to-back windows have no gap cycle.
    - Else store final value internally and go HOLD.
- HOLD (busy=1):
  - Events are ignored (not counted).
  - When output register frees (same rule as above): load stored result; if enable go COUNT with fresh window (timer/acc reload as IDLE), else go IDLE.
  - enable low in HOLD does not drop the stored result.
- Handshake:
  - Transfer occurs when count_valid & count_ready at posedge; count_valid drops next cycle unless a new result loads the same cycle.
  - count_out/overflow stable while count_valid high and not accepted.
  - count_ready ignored when count_valid==0.
- Latency: result visible (count_valid high) the cycle after a window's last cycle, when output is free.
- Simultaneous events:
  - Accept plus new load in same cycle: count_valid stays 1, data updates.
  - Reset overrides all.

Test Plan:
- Reset low 3 cycles with synch_in toggling -> all outputs 0, busy=0; release reset, enable=0 -> stays IDLE.
- window_len=100, count_ready=1, 7 single-cycle synch_in pulses spaced 10 cycles apart inside window -> count_valid one cycle after cycle 100, count_out=7, overflow=0; next window starts with no gap.
- synch_in held high 5 cycles, 3 times, window_len=50 -> count_out=3. Pulse on last window cycle -> included in that window's result.
- CNT_W=4, 20 pulses in window_len=200 -> count_out=15, overflow=1.
- count_ready=0 through two windows of len=20 (2 and 4 pulses) -> first result count_out=2 held, FSM in HOLD, pulses ignored; raise count_ready -> count_out=2 accepted, then count_out=4 loads next cycle.
- enable dropped at cycle 30 of len=100 window -> no result, busy=0 next cycle. window_len=0 with 1 pulse -> 1-cycle windows, count_out=1 then 0.
